iiitb_elc_dispatch: RTL
=======================

IIITB_ELC_DISPATCH -- requirements
Module: iiitb_elc_dispatch

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 8: cycles held in DWELL after a floor is served.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096: WAIT_DONE watchdog limit; used only when ELC_DISPATCH_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port call_buttons  in  8  floor-call presses; bit i is floor i; multi-hot allowed; any width of pulse.
REQ-006 SHALL have port current_floor  in  8  one-hot floor position from the elevator controller.
REQ-007 SHALL have port complete  in  1  controller reports arrival at the requested floor.
REQ-008 SHALL have ports door_alert and weight_alert  in  1 each  controller alert flags.
REQ-009 SHALL have port request_floor  out  8  one-hot target floor driven to the controller.
REQ-010 SHALL have port req_valid  out  1  high while request_floor holds a live target.
REQ-011 SHALL have port pending  out  8  latched, unserved calls.
REQ-012 SHALL have ports sweep_up (out 1, current sweep direction; 1 = up) and busy (out 1, state != IDLE).
REQ-013 SHALL have port fault  out  1  sticky watchdog flag; tied 0 when the watchdog is compiled out.

Function
REQ-014 Each cycle SHALL compute pending_next = (pending | call_buttons) & ~served_mask.
- served_mask is the one-hot target in the cycle served; clear wins over a simultaneous press of the same floor.
REQ-015 The FSM SHALL have five states: IDLE, SELECT, ISSUE, WAIT_DONE, DWELL.
REQ-016 IDLE -> SELECT on the cycle after pending != 0.
- If the only pending bit equals current_floor, that bit SHALL clear and the FSM SHALL go to DWELL without issuing.
REQ-017 SELECT SHALL choose the target in one cycle using SCAN.
- First choice: the nearest pending floor strictly beyond current_floor in the sweep_up direction.
- If none exists, sweep_up SHALL toggle and the nearest floor in the new direction SHALL be chosen.
- Floor 0 and floor 7 are the bounds; there is no wrap-around.
REQ-018 ISSUE SHALL register request_floor and assert req_valid; the FSM SHALL move to WAIT_DONE the next cycle. Latency from the first press in IDLE to req_valid SHALL be 3 cycles.
REQ-019 request_floor SHALL stay stable while req_valid=1; new presses SHALL NOT retarget an in-flight request.
REQ-020 WAIT_DONE -> DWELL when complete=1 and current_floor==request_floor in the same cycle.
- That cycle clears the pending bit; req_valid deasserts the following cycle.
REQ-021 While door_alert or weight_alert is 1, the FSM SHALL hold its state and counters.
- Presses SHALL still latch; no new request SHALL issue.
REQ-022 A current_floor that is not one-hot SHALL freeze SELECT and ISSUE until the value is valid again.
REQ-023 DWELL SHALL count DWELL_CYCLES, then go to SELECT if pending != 0, else to IDLE.
REQ-024 With pending == 8'h00 the block SHALL sit in IDLE with req_valid=0 indefinitely.

Reset
REQ-025 reset=0 SHALL asynchronously force the following, regardless of state:
- FSM to IDLE; pending, request_floor and counters to 0.
- req_valid=0, sweep_up=1, busy=0, fault=0.
REQ-026 Releasing reset SHALL take effect at the next posedge clk; a press in the release cycle SHALL be latched.

Configuration
REQ-027 With ELC_DISPATCH_TIMEOUT_EN defined, a watchdog SHALL count cycles in WAIT_DONE.
- On reaching TIMEOUT_CYCLES: set fault (sticky until reset), drop the target's pending bit, deassert req_valid, go to SELECT.
- Alert-hold cycles SHALL NOT count toward the limit.
REQ-028 Without ELC_DISPATCH_TIMEOUT_EN, no watchdog logic SHALL exist, fault SHALL be constant 0, and WAIT_DONE waits indefinitely.

Verification
REQ-029 Reset, current_floor=8'h01, one-cycle press of call_buttons=8'h10 -> req_valid=1 and request_floor=8'h10 three cycles later; pending=8'h10.
REQ-030 At floor 8'h04 with sweep_up=1, pending=8'h03 then 8'h41 pressed -> serve order 8'h40, then 8'h02, then 8'h01; sweep_up toggles once.
REQ-031 In WAIT_DONE to 8'h20, press 8'h20 and drive complete with current_floor=8'h20 in the same cycle -> pending bit 5 ends 0; DWELL lasts 8 cycles.
REQ-032 weight_alert=1 for 20 cycles during DWELL -> state frozen, presses latched, no new req_valid until the alert drops.
REQ-033 With ELC_DISPATCH_TIMEOUT_EN and TIMEOUT_CYCLES=16, complete held 0 -> fault=1 at cycle 16 of WAIT_DONE, the target's pending bit cleared, next target selected.
REQ-034 Assert reset mid-WAIT_DONE -> all outputs reach reset values with no clock edge; after release, state is IDLE.

Source files
------------

// File: rtl/iiitb_elc_dispatch.sv
// ----------------------------------------------------------------------------
// iiitb_elc_dispatch
//
// Purpose: elevator call dispatcher for an 8-floor shaft. It latches floor
// calls, picks the next target with a SCAN (elevator) policy, and issues one
// one-hot request at a time to the elevator controller. After each arrival it
// holds in DWELL for DWELL_CYCLES cycles.
//
// Ports:
//   clk            in   single clock, all state updates on posedge
//   reset          in   asynchronous, active-low reset
//   call_buttons   in   [7:0] floor-call presses, multi-hot, any pulse width
//   current_floor  in   [7:0] one-hot cabin position
//   complete       in   controller reports arrival at the requested floor
//   door_alert     in   alert flag; freezes the FSM while high
//   weight_alert   in   alert flag; freezes the FSM while high
//   request_floor  out  [7:0] one-hot target floor
//   req_valid      out  request_floor holds a live target
//   pending        out  [7:0] latched, unserved calls
//   sweep_up       out  current sweep direction (1 = up)
//   busy           out  FSM is not idle
//   fault          out  sticky watchdog flag
//
// Optional feature: define ELC_DISPATCH_TIMEOUT_EN to build the WAIT_DONE
// watchdog (limit TIMEOUT_CYCLES). Without it fault is constant 0 and the
// FSM waits for completion indefinitely.
// ----------------------------------------------------------------------------
module iiitb_elc_dispatch #(
    parameter int DWELL_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] call_buttons,
    input  logic [7:0] current_floor,
    input  logic       complete,
    input  logic       door_alert,
    input  logic       weight_alert,
    output logic [7:0] request_floor,
    output logic       req_valid,
    output logic [7:0] pending,
    output logic       sweep_up,
    output logic       busy,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_ISSUE, S_WAIT_DONE, S_DWELL
    } state_t;

    localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    state_t            state_q;
    logic [7:0]        pending_q, pending_d;
    logic [7:0]        target_q;
    logic [7:0]        request_floor_q;
    logic              req_valid_q;
    logic              sweep_up_q;
    logic [DW_W-1:0]   dwell_cnt_q;
    logic [7:0]        served_mask;

    logic              hold;
    logic              floor_ok;
    logic              arrived;
    logic [7:0]        above_mask, below_mask;
    logic [7:0]        up_cand, dn_cand;
    logic [7:0]        pick;
    logic              pick_found, pick_toggle;

`ifdef ELC_DISPATCH_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WD_W-1:0]   wd_cnt_q;
    logic              fault_q;
    logic              wd_hit;
    assign wd_hit = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign fault  = fault_q;
`else
    assign fault  = 1'b0;
`endif

    // Isolate the lowest / highest set bit of a floor vector.
    function automatic logic [7:0] lsb_only(input logic [7:0] x);
        return x & (~x + 8'd1);
    endfunction

    function automatic logic [7:0] msb_only(input logic [7:0] x);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) r = 8'd1 << i;    // later (higher) bits overwrite
        end
        return r;
    endfunction

    // Floors strictly above / below the cabin, derived from the one-hot position.
    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
        if (gi == 0) begin : g_lo
            assign above_mask[gi] = 1'b0;
        end else begin : g_lo
            assign above_mask[gi] = |current_floor[gi-1:0];
        end
        if (gi == 7) begin : g_hi
            assign below_mask[gi] = 1'b0;
        end else begin : g_hi
            assign below_mask[gi] = |current_floor[7:gi+1];
        end
    end

    assign hold     = door_alert | weight_alert;
    assign floor_ok = $onehot(current_floor);
    assign arrived  = complete && (current_floor == request_floor_q);
    assign up_cand  = pending_q & above_mask;
    assign dn_cand  = pending_q & below_mask;

    // SCAN choice: keep going in the sweep direction; reverse only when the
    // sweep direction has nothing left.
    always_comb begin
        pick        = '0;
        pick_found  = 1'b0;
        pick_toggle = 1'b0;
        if (sweep_up_q) begin
            if (|up_cand) begin
                pick = lsb_only(up_cand);  pick_found = 1'b1;
            end else if (|dn_cand) begin
                pick = msb_only(dn_cand);  pick_found = 1'b1;  pick_toggle = 1'b1;
            end
        end else begin
            if (|dn_cand) begin
                pick = msb_only(dn_cand);  pick_found = 1'b1;
            end else if (|up_cand) begin
                pick = lsb_only(up_cand);  pick_found = 1'b1;  pick_toggle = 1'b1;
            end
        end
    end

    // Floor whose call is retired this cycle; the clear beats a same-cycle press.
    always_comb begin
        served_mask = '0;
        if (!hold) begin
            case (state_q)
                S_IDLE:
                    if ((|pending_q) && floor_ok && (pending_q == current_floor))
                        served_mask = current_floor;
                S_SELECT:
                    // Nothing beyond in either direction: the only call left
                    // is the floor the cabin already stands at.
                    if (floor_ok && !pick_found)
                        served_mask = pending_q & current_floor;
                S_WAIT_DONE:
                    if (arrived)
                        served_mask = request_floor_q;
`ifdef ELC_DISPATCH_TIMEOUT_EN
                    else if (wd_hit)
                        served_mask = request_floor_q;
`endif
                default: served_mask = '0;
            endcase
        end
    end

    assign pending_d = (pending_q | call_buttons) & ~served_mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            pending_q       <= '0;
            target_q        <= '0;
            request_floor_q <= '0;
            req_valid_q     <= 1'b0;
            sweep_up_q      <= 1'b1;
            dwell_cnt_q     <= '0;
`ifdef ELC_DISPATCH_TIMEOUT_EN
            wd_cnt_q        <= '0;
            fault_q         <= 1'b0;
`endif
        end else begin
            pending_q <= pending_d;
            if (!hold) begin
                case (state_q)
                    S_IDLE: begin
                        if (|pending_q) begin
                            if (|served_mask) begin
                                state_q     <= S_DWELL;
                                dwell_cnt_q <= '0;
                            end else begin
                                state_q <= S_SELECT;
                            end
                        end
                    end
                    S_SELECT: begin
                        if (floor_ok) begin
                            if (pick_found) begin
                                target_q <= pick;
                                if (pick_toggle) sweep_up_q <= ~sweep_up_q;
                                state_q  <= S_ISSUE;
                            end else if (|served_mask) begin
                                state_q     <= S_DWELL;
                                dwell_cnt_q <= '0;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                    end
                    S_ISSUE: begin
                        if (floor_ok) begin
                            request_floor_q <= target_q;
                            req_valid_q     <= 1'b1;
                            state_q         <= S_WAIT_DONE;
`ifdef ELC_DISPATCH_TIMEOUT_EN
                            wd_cnt_q        <= '0;
`endif
                        end
                    end
                    S_WAIT_DONE: begin
                        if (arrived) begin
                            req_valid_q <= 1'b0;
                            state_q     <= S_DWELL;
                            dwell_cnt_q <= '0;
                        end
`ifdef ELC_DISPATCH_TIMEOUT_EN
                        else if (wd_hit) begin
                            fault_q     <= 1'b1;
                            req_valid_q <= 1'b0;
                            wd_cnt_q    <= '0;
                            state_q     <= S_SELECT;
                        end else begin
                            wd_cnt_q <= wd_cnt_q + 1'b1;
                        end
`endif
                    end
                    S_DWELL: begin
                        if (dwell_cnt_q == DW_W'(DWELL_CYCLES - 1)) begin
                            dwell_cnt_q <= '0;
                            state_q     <= (|pending_d) ? S_SELECT : S_IDLE;
                        end else begin
                            dwell_cnt_q <= dwell_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign request_floor = request_floor_q;
    assign req_valid     = req_valid_q;
    assign pending       = pending_q;
    assign sweep_up      = sweep_up_q;
    assign busy          = (state_q != S_IDLE);

endmodule
